mem_port_arbiter: RTL and testbench

- Arbitrates the single-port unified data/instruction memory (16K words, instruction image in words 0..1023) between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sits between the pipeline stages and the memory array.
- Issues one access per cycle and routes read data back with 1-cycle latency.
- Uses MEM-priority arbitration, with a starvation limit that guarantees IF forward progress; also supports a squash of in-flight IF reads on branch redirect.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
// MEM has priority; a streak limit forces an IF grant so fetch keeps making progress.
module mem_port_arbiter #(
  parameter int ADDR_LINE_MEM = 14,
  parameter int D_SIZE        = 32,
  parameter int MAX_STREAK    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDR_LINE_MEM-1:0] if_addr,
  input  logic                     if_flush,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [D_SIZE-1:0]        if_rdata,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic [ADDR_LINE_MEM-1:0] mem_addr,
  input  logic [D_SIZE-1:0]        mem_wdata,
  output logic                     mem_gnt,
  output logic                     mem_rvalid,
  output logic [D_SIZE-1:0]        mem_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_LINE_MEM-1:0] ram_addr,
  output logic [D_SIZE-1:0]        ram_wdata,
  input  logic [D_SIZE-1:0]        ram_rdata,
  output logic [3:0]               streak_cnt
);

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_IF,
    RSP_MEM
  } rsp_state_e;

  localparam logic [3:0] StreakLimit = 4'(MAX_STREAK);

  rsp_state_e rspState_q;
  rsp_state_e rspState_d;
  logic [3:0] streak_q;
  logic [3:0] streak_d;
  logic       ifGnt;
  logic       memGnt;

  // Grants are suppressed while reset is high so nothing reaches the array.
  always_comb begin
    ifGnt  = 1'b0;
    memGnt = 1'b0;
    if (!reset) begin
      if (mem_req && if_req) begin
        if (streak_q == StreakLimit) begin
          ifGnt = 1'b1;
        end else begin
          memGnt = 1'b1;
        end
      end else if (mem_req) begin
        memGnt = 1'b1;
      end else if (if_req) begin
        ifGnt = 1'b1;
      end
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (ifGnt || !if_req) begin
      streak_d = 4'd0;
    end else if (memGnt && (streak_q != StreakLimit)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // A flushed IF grant still accesses the array but never arms a response.
  always_comb begin
    rspState_d = RSP_IDLE;
    if (ifGnt && !if_flush) begin
      rspState_d = RSP_IF;
    end else if (memGnt && !mem_we) begin
      rspState_d = RSP_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rspState_q <= RSP_IDLE;
      streak_q   <= 4'd0;
    end else begin
      rspState_q <= rspState_d;
      streak_q   <= streak_d;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    if (memGnt) begin
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (ifGnt) begin
      ram_addr  = if_addr;
    end
  end

  assign if_gnt     = ifGnt;
  assign mem_gnt    = memGnt;
  assign ram_en     = ifGnt | memGnt;
  assign ram_we     = memGnt & mem_we;
  assign streak_cnt = streak_q;

  assign if_rvalid  = !reset && (rspState_q == RSP_IF) && !if_flush;
  assign mem_rvalid = !reset && (rspState_q == RSP_MEM);
  assign if_rdata   = if_rvalid ? ram_rdata : '0;
  assign mem_rdata  = mem_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, reference arbitration model and a
// response scoreboard, plus directed checks for the reset, RAW, starvation and flush cases.
module tb_mem_port_arbiter;

  localparam int AW        = 14;
  localparam int DW        = 32;
  localparam int StreakMax = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [3:0]    streak_cnt;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;

  logic [DW-1:0] ramArray [0:16383];
  logic [DW-1:0] refMem   [0:16383];
  rsp_t          ifQ[$];
  rsp_t          memQ[$];
  int            modelStreak = 0;

  logic          eIfG, eMemG, eIfV, eMemV;
  logic [DW-1:0] eIfD, eMemD, eWd;
  logic [AW-1:0] eAddr;

  mem_port_arbiter #(.ADDR_LINE_MEM(AW), .D_SIZE(DW), .MAX_STREAK(StreakMax)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .streak_cnt(streak_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port array with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en && ram_we) ramArray[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= ramArray[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ifReq, input logic [AW-1:0] ifAddr,
                               input logic ifFlush, input logic memReq, input logic memWe,
                               input logic [AW-1:0] memAddr, input logic [DW-1:0] memWdata);
    @(posedge clk);
    #1;
    reset     = rst;
    if_req    = ifReq;
    if_addr   = ifAddr;
    if_flush  = ifFlush;
    mem_req   = memReq;
    mem_we    = memWe;
    mem_addr  = memAddr;
    mem_wdata = memWdata;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Reference model and scoreboard, evaluated mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (reset) begin
      ifQ.delete();
      memQ.delete();
    end
    eIfG  = 1'b0;
    eMemG = 1'b0;
    if (!reset) begin
      if (if_req && mem_req) begin
        if (modelStreak == StreakMax) eIfG = 1'b1;
        else eMemG = 1'b1;
      end else if (mem_req) begin
        eMemG = 1'b1;
      end else if (if_req) begin
        eIfG = 1'b1;
      end
    end
    eAddr = eMemG ? mem_addr : (eIfG ? if_addr : '0);
    eWd   = eMemG ? mem_wdata : '0;
    checkOutput("ifGnt", if_gnt, eIfG);
    checkOutput("memGnt", mem_gnt, eMemG);
    checkOutput("ramEn", ram_en, eIfG | eMemG);
    checkOutput("ramWe", ram_we, eMemG & mem_we);
    checkOutput("ramAddr", ram_addr, eAddr);
    checkOutput("ramWdata", ram_wdata, eWd);
    checkOutput("streakCnt", streak_cnt, 4'(modelStreak));

    eIfV = 1'b0;
    eIfD = '0;
    if (ifQ.size() > 0 && ifQ[0].due == cyc) begin
      eIfV = !if_flush;
      if (eIfV) eIfD = ifQ[0].data;
      void'(ifQ.pop_front());
    end
    eMemV = 1'b0;
    eMemD = '0;
    if (memQ.size() > 0 && memQ[0].due == cyc) begin
      eMemV = 1'b1;
      eMemD = memQ[0].data;
      void'(memQ.pop_front());
    end
    checkOutput("ifRvalid", if_rvalid, eIfV);
    checkOutput("ifRdata", if_rdata, eIfD);
    checkOutput("memRvalid", mem_rvalid, eMemV);
    checkOutput("memRdata", mem_rdata, eMemD);

    if (eIfG && !if_flush) ifQ.push_back('{due: cyc + 1, data: refMem[if_addr]});
    if (eMemG) begin
      if (mem_we) refMem[mem_addr] = mem_wdata;
      else memQ.push_back('{due: cyc + 1, data: refMem[mem_addr]});
    end

    if (reset || eIfG || !if_req) modelStreak = 0;
    else if (eMemG && modelStreak < StreakMax) modelStreak = modelStreak + 1;
  end

  logic [DW-1:0] ifPre [0:2];
  logic [DW-1:0] savedWord;

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 16384; i++) begin
      ramArray[i] = $urandom;
      refMem[i]   = ramArray[i];
    end
    ifPre[0] = 32'h11; ifPre[1] = 32'h22; ifPre[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      ramArray[i] = ifPre[i];
      refMem[i]   = ifPre[i];
    end

    $display("[TB] reset with both requests high");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 14'd3, 1'b0, 1'b1, 1'b0, 14'd7, '0);
      @(negedge clk);
      checkOutput("rstGnt", {if_gnt, mem_gnt, ram_en, ram_we}, 4'b0000);
      checkOutput("rstRvalid", {if_rvalid, mem_rvalid}, 2'b00);
      checkOutput("rstStreak", streak_cnt, 4'd0);
    end

    $display("[TB] IF-only fetch stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, i < 3, AW'(i), 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (i < 3) checkOutput("ifOnlyGnt", if_gnt, 1'b1);
      if (i > 0) checkOutput("ifOnlyData", if_rdata, ifPre[i-1]);
    end

    $display("[TB] store then load same address");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 14'd1500, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("stwRamWe", ram_we, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 14'd1500, '0);
    @(negedge clk);
    checkOutput("ldwGnt", mem_gnt, 1'b1);
    idleCycle();
    @(negedge clk);
    checkOutput("rawData", mem_rdata, 32'hDEADBEEF);

    $display("[TB] starvation limit");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 14'd5, 1'b0, 1'b1, 1'b0, 14'd100, '0);
      @(negedge clk);
      checkOutput("starveIfGnt", if_gnt, (i % 5) == 4);
      checkOutput("starveStreak", streak_cnt, 4'(i % 5));
    end
    idleCycle();
    idleCycle();

    $display("[TB] branch flush");
    applyStimulus(1'b0, 1'b1, 14'd8, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 14'd200, '0);
    @(negedge clk);
    checkOutput("flushRvalid", if_rvalid, 1'b0);
    checkOutput("flushMemGnt", mem_gnt, 1'b1);
    applyStimulus(1'b0, 1'b1, 14'd9, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("flushMemRvalid", mem_rvalid, 1'b1);
    checkOutput("flushGrantCycle", if_gnt, 1'b1);
    idleCycle();
    @(negedge clk);
    checkOutput("flushGrantNoRsp", if_rvalid, 1'b0);

    $display("[TB] reset during outstanding load");
    savedWord = refMem[300];
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 14'd300, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("midRstRvalid1", mem_rvalid, 1'b0);
    idleCycle();
    @(negedge clk);
    checkOutput("midRstRvalid2", mem_rvalid, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 14'd300, '0);
    @(negedge clk);
    checkOutput("postRstGnt", mem_gnt, 1'b1);
    idleCycle();
    @(negedge clk);
    checkOutput("postRstData", mem_rdata, savedWord);

    idleCycle();
    idleCycle();
    @(negedge clk);
    checkOutput("sbDrain", ifQ.size() + memQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
